systolic_load_ctrl: RTL
=======================

Name: systolic_load_ctrl

Overview:
- Sequences one matrix-multiply pass of the TPU datapath.
- Clears the MAC array, then accepts DIM A/B rows from the host via a valid/ready handshake and writes them into the A and B transpose memories.
- Then streams the array for the fixed skew-plus-compute window, with downstream stall, and pulses done.
- Sits between the host/loader and memA, memB and the tpumac grid.

Parameters:
- DIM, 8, matrix dimension; number of rows loaded and size of the systolic array.
- STREAM_LEN, 3*DIM-2, number of non-stalled streaming cycles per pass (22 at DIM=8).
- CNT_W, $clog2(3*DIM-1), width of the stream counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a pass; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE without done.
- row_valid  input  1  host presents A row and B row for the current wr_row.
- row_ready  output  1  controller accepts a row this cycle.
- stall  input  1  downstream not ready; freezes streaming.
- a_wren  output  1  write enable to memA (WrEn).
- b_wren  output  1  write enable to memB.
- wr_row  output  $clog2(DIM)  row index for the memory writes (Arow).
- fifo_en  output  1  shift enable to memA/memB transpose FIFOs (en).
- mac_en  output  1  enable to tpumac array.
- mac_clr  output  1  clears MAC accumulators.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of pass.

Behaviour:
- States: IDLE, CLEAR, LOAD, STREAM, DONE. State register, row counter and stream counter are registered. Outputs are decoded from state and counters plus the row_valid/stall inputs as listed below.
- Reset (rst=1 at an edge): state=IDLE, row_cnt=0, stream_cnt=0. Resulting outputs: row_ready=0, a_wren=0, b_wren=0, wr_row=0, fifo_en=0, mac_en=0, mac_clr=0, busy=0, done=0. Reset mid-pass discards all progress.
- IDLE: start=1 and abort=0 -> CLEAR. start while not IDLE is ignored.
- CLEAR: exactly 1 cycle. mac_clr=1; row_cnt and stream_cnt cleared -> LOAD.
- LOAD:
  - row_ready=1.
  - a_wren = b_wren = row_valid; fifo_en = row_valid; wr_row = row_cnt.
  - On handshake (row_valid=1) row_cnt increments.
  - Handshake with row_cnt==DIM-1 -> STREAM with row_cnt back to 0.
  - row_valid=0 holds state with no writes; idle gaps are unbounded.
  - stall is ignored in LOAD.
- STREAM:
  - fifo_en = mac_en = !stall.
  - stream_cnt increments on each non-stalled cycle.
  - Non-stalled cycle with stream_cnt==STREAM_LEN-1 -> DONE.
  - Stalled cycles never count; a stall on the last cycle delays the exit.
  - row_ready=0 and no writes occur.
- DONE: done=1 for exactly 1 cycle, busy still 1 -> IDLE. A start arriving in DONE is ignored; it must be reasserted in IDLE.
- abort=1 in any non-IDLE state -> IDLE next cycle, counters cleared, no done.
  - Outputs in the abort cycle follow the current state, so a LOAD write in that cycle still occurs.
  - abort together with start in IDLE: abort wins, stay IDLE.
- Precedence: rst > abort > all state transitions.
- Minimum pass length with no gaps or stalls: 1 + DIM + STREAM_LEN + 1 cycles (32 at DIM=8), from the first CLEAR cycle through the DONE cycle inclusive.

Test Plan:
- Reset then start=1 for 1 cycle, row_valid held 1, stall=0 -> mac_clr high at cycle 1 only.
  - a_wren high cycles 2-9 with wr_row 0..7.
  - fifo_en/mac_en high cycles 10-31 (22 cycles); done pulse at cycle 32; busy high cycles 1-32.
- LOAD with row_valid toggling 1,0,1,0 -> wr_row advances only on valid cycles, 8 writes total.
  - No write occurs when row_valid=0; STREAM entered only after the 8th handshake.
- STREAM with stall high for 5 cycles after 10 counted cycles -> mac_en/fifo_en low during the stall.
  - Exactly 22 mac_en cycles total; done is delayed by exactly 5 cycles versus the no-stall pass.
- abort at 4th LOAD handshake -> that write (wr_row=3) occurs, then IDLE, busy=0, done never asserts.
  - A following start restarts from wr_row=0 with mac_clr.
- rst asserted mid-STREAM (stream_cnt=7) -> next cycle all outputs 0 and state IDLE.
  - start pulses during busy and in the DONE cycle are ignored (no second pass).
- start and abort together in IDLE -> remains IDLE, busy=0; start alone next cycle -> CLEAR.

Source files
------------

// File: rtl/systolic_load_ctrl.sv
// Pass sequencer for the systolic MAC datapath: clear the array, load DIM A/B rows
// into the transpose memories, stream the skew-plus-compute window, then pulse done.
module systolic_load_ctrl #(
  parameter int DIM        = 8,
  parameter int STREAM_LEN = 3*DIM-2,
  parameter int CNT_W      = $clog2(3*DIM-1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic                   stall,
  output logic                   a_wren,
  output logic                   b_wren,
  output logic [$clog2(DIM)-1:0] wr_row,
  output logic                   fifo_en,
  output logic                   mac_en,
  output logic                   mac_clr,
  output logic                   busy,
  output logic                   done
);

  localparam int ROW_W = $clog2(DIM);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM-1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STREAM_LEN-1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, STREAM, DONE} state_t;

  state_t           state_reg, state_next;
  logic [ROW_W-1:0] row_cnt_reg, row_cnt_next;
  logic [CNT_W-1:0] stream_cnt_reg, stream_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      row_cnt_reg    <= '0;
      stream_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      row_cnt_reg    <= row_cnt_next;
      stream_cnt_reg <= stream_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    row_cnt_next    = row_cnt_reg;
    stream_cnt_next = stream_cnt_reg;
    row_ready       = 1'b0;
    a_wren          = 1'b0;
    b_wren          = 1'b0;
    fifo_en         = 1'b0;
    mac_en          = 1'b0;
    mac_clr         = 1'b0;
    done            = 1'b0;
    busy            = (state_reg != IDLE);
    wr_row          = row_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start && !abort) state_next = CLEAR;
      end
      CLEAR: begin
        mac_clr         = 1'b1;
        row_cnt_next    = '0;
        stream_cnt_next = '0;
        state_next      = LOAD;
      end
      LOAD: begin
        row_ready = 1'b1;
        a_wren    = row_valid;
        b_wren    = row_valid;
        fifo_en   = row_valid;
        if (row_valid) begin
          if (row_cnt_reg == ROW_LAST) begin
            row_cnt_next = '0;
            state_next   = STREAM;
          end else begin
            row_cnt_next = row_cnt_reg + 1'b1;
          end
        end
      end
      STREAM: begin
        fifo_en = !stall;
        mac_en  = !stall;
        // Only non-stalled cycles advance the skew/compute window.
        if (!stall) begin
          if (stream_cnt_reg == CNT_LAST) begin
            stream_cnt_next = '0;
            state_next      = DONE;
          end else begin
            stream_cnt_next = stream_cnt_reg + 1'b1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides the transition only; this cycle's outputs still follow the state.
    if (abort && state_reg != IDLE) begin
      state_next      = IDLE;
      row_cnt_next    = '0;
      stream_cnt_next = '0;
    end
  end

endmodule
